addsub_pipelined_16_bit: RTL

//  Two-stage pipelined add/subtract unit feeding the 4-bit carry-lookahead carry generator.

---
 rtl/addsub_pipelined_16_bit.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/addsub_pipelined_16_bit.sv
// Two-stage pipelined add/subtract unit: stage 1 registers bit propagate/generate,
// stage 2 resolves carries with 4-bit lookahead groups and registers result plus S/Z/CY/OV.
module addsub_pipelined_16_bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_s,
    output logic             flag_z,
    output logic             flag_cy,
    output logic             flag_ov
);

    localparam int NGRP = WIDTH / 4;

    // Carries out of each bit of one 4-bit group, all in sum-of-products form.
    function automatic logic [3:0] cla4_carries(input logic [3:0] p, input logic [3:0] g,
                                                input logic c0);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & c0);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic grp_prop(input logic [3:0] p);
        return &p;
    endfunction

    // Carry into every group, each expanded directly from cin and group G/P terms.
    function automatic logic [NGRP-1:0] grp_carries(input logic [NGRP-1:0] gg,
                                                    input logic [NGRP-1:0] gp,
                                                    input logic c0);
        logic [NGRP-1:0] c;
        logic            term;
        logic            acc;
        for (int k = 0; k < NGRP; k++) begin
            acc = c0;
            for (int j = 0; j < k; j++) begin
                acc = acc & gp[j];
            end
            for (int j = 0; j < k; j++) begin
                term = gg[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & gp[m];
                end
                acc = acc | term;
            end
            c[k] = acc;
        end
        return c;
    endfunction

    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             a_msb_q, a_msb_d;
    logic             bx_msb_q, bx_msb_d;
    logic             cin_q, cin_d;
    logic             s1_valid_q, s1_valid_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_s_q, flag_s_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_cy_q, flag_cy_d;
    logic             flag_ov_q, flag_ov_d;

    logic [WIDTH-1:0] bx_s;
    logic             cin_s;
    logic             s2_adv_s;
    logic             in_ready_s;
    logic             s1_load_s;
    logic             out_load_s;

    logic [NGRP-1:0]  grp_g_s;
    logic [NGRP-1:0]  grp_p_s;
    logic [NGRP-1:0]  grp_cin_s;
    logic [WIDTH-1:0] c_s;
    logic [WIDTH-1:0] sum_s;
    logic             cy_s;
    logic             ov_s;

    // Handshake: stage 2 advances when the output slot is empty or being drained.
    always_comb begin
        s2_adv_s   = !out_valid_q | out_ready;
        in_ready_s = !s1_valid_q | s2_adv_s;
        s1_load_s  = in_valid & in_ready_s;
        out_load_s = s1_valid_q & s2_adv_s;
    end

    // Operand transform and carry-in selection; ADD forces 0, SUB forces 1.
    always_comb begin
        bx_s = b;
        if (op[1]) begin
            bx_s = ~b;
        end else begin
            bx_s = b;
        end
        cin_s = 1'b0;
        case (op)
            2'b00:   cin_s = 1'b0;
            2'b01:   cin_s = carry_in;
            2'b10:   cin_s = 1'b1;
            2'b11:   cin_s = carry_in;
            default: cin_s = 1'b0;
        endcase
    end

    // Stage 1 next state: capture a new beat, hold a stalled one, or empty out.
    always_comb begin
        p_d        = p_q;
        g_d        = g_q;
        a_msb_d    = a_msb_q;
        bx_msb_d   = bx_msb_q;
        cin_d      = cin_q;
        s1_valid_d = s1_valid_q & !s2_adv_s;
        if (s1_load_s) begin
            p_d        = a ^ bx_s;
            g_d        = a & bx_s;
            a_msb_d    = a[WIDTH-1];
            bx_msb_d   = bx_s[WIDTH-1];
            cin_d      = cin_s;
            s1_valid_d = 1'b1;
        end else begin
            s1_valid_d = s1_valid_q & !s2_adv_s;
        end
    end

    // Stage 2 carry resolution: group G/P, group lookahead, then in-group lookahead.
    always_comb begin
        for (int k = 0; k < NGRP; k++) begin
            grp_g_s[k] = grp_gen(p_q[4*k +: 4], g_q[4*k +: 4]);
            grp_p_s[k] = grp_prop(p_q[4*k +: 4]);
        end
        grp_cin_s = grp_carries(grp_g_s, grp_p_s, cin_q);
        for (int k = 0; k < NGRP; k++) begin
            c_s[4*k +: 4] = cla4_carries(p_q[4*k +: 4], g_q[4*k +: 4], grp_cin_s[k]);
        end
        sum_s = p_q ^ {c_s[WIDTH-2:0], cin_q};
        cy_s  = c_s[WIDTH-1];
        ov_s  = (a_msb_q == bx_msb_q) & (sum_s[WIDTH-1] != a_msb_q);
    end

    // Output register next state: load from stage 1, clear on drain, else hold.
    always_comb begin
        result_d    = result_q;
        flag_s_d    = flag_s_q;
        flag_z_d    = flag_z_q;
        flag_cy_d   = flag_cy_q;
        flag_ov_d   = flag_ov_q;
        out_valid_d = out_valid_q;
        if (out_load_s) begin
            result_d    = sum_s;
            flag_s_d    = sum_s[WIDTH-1];
            flag_z_d    = (sum_s == {WIDTH{1'b0}});
            flag_cy_d   = cy_s;
            flag_ov_d   = ov_s;
            out_valid_d = 1'b1;
        end else if (s2_adv_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q         <= {WIDTH{1'b0}};
            g_q         <= {WIDTH{1'b0}};
            a_msb_q     <= 1'b0;
            bx_msb_q    <= 1'b0;
            cin_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            flag_s_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_cy_q   <= 1'b0;
            flag_ov_q   <= 1'b0;
        end else begin
            p_q         <= p_d;
            g_q         <= g_d;
            a_msb_q     <= a_msb_d;
            bx_msb_q    <= bx_msb_d;
            cin_q       <= cin_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_s_q    <= flag_s_d;
            flag_z_q    <= flag_z_d;
            flag_cy_q   <= flag_cy_d;
            flag_ov_q   <= flag_ov_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_s    = flag_s_q;
    assign flag_z    = flag_z_q;
    assign flag_cy   = flag_cy_q;
    assign flag_ov   = flag_ov_q;

endmodule
